// File: rtl/issue_scoreboard_ctrl.sv
// -----------------------------------------------------------------------------
// issue_scoreboard_ctrl
//   Issue sequencer and register scoreboard for the dual-issue front end.
//   Keeps one countdown counter per architectural register (cycles until a
//   pending result is ready). It feeds the six source-register counts to the
//   external dependence checker. It then acts on the checker's
//   both_stall/single_stall verdict and issues the two slots of a bundle,
//   either together or split over cycles.
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   bundle_valid / bundle_ready decode handshake; ready = bundle fully issued
//   flush                       drop the bundle in progress
//   rd_addr_1..3 / rd_addr_4..6 slot-1 / slot-2 source registers
//   rd_en_1, rd_en_2            slot source-read enables
//   wr_addr_n, wr_en_n, lat_n   slot destination, write enable, latency
//   both_stall, single_stall    verdict from the dependence checker
//   avail_cnt_1..6              counter[rd_addr_n], read of registered state
//   single_stall_reg            high while slot 1 is issued and slot 2 pending
//   issue_1, issue_2            slot-n instruction issued this cycle
// -----------------------------------------------------------------------------
module issue_scoreboard_ctrl #(
  parameter int REG_AW = 7,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bundle_valid,
  output logic              bundle_ready,
  input  logic              flush,
  input  logic [REG_AW-1:0] rd_addr_1,
  input  logic [REG_AW-1:0] rd_addr_2,
  input  logic [REG_AW-1:0] rd_addr_3,
  input  logic [REG_AW-1:0] rd_addr_4,
  input  logic [REG_AW-1:0] rd_addr_5,
  input  logic [REG_AW-1:0] rd_addr_6,
  input  logic              rd_en_1,
  input  logic              rd_en_2,
  input  logic [REG_AW-1:0] wr_addr_1,
  input  logic [REG_AW-1:0] wr_addr_2,
  input  logic              wr_en_1,
  input  logic              wr_en_2,
  input  logic [CNT_W-1:0]  lat_1,
  input  logic [CNT_W-1:0]  lat_2,
  input  logic              both_stall,
  input  logic              single_stall,
  output logic [CNT_W-1:0]  avail_cnt_1,
  output logic [CNT_W-1:0]  avail_cnt_2,
  output logic [CNT_W-1:0]  avail_cnt_3,
  output logic [CNT_W-1:0]  avail_cnt_4,
  output logic [CNT_W-1:0]  avail_cnt_5,
  output logic [CNT_W-1:0]  avail_cnt_6,
  output logic              single_stall_reg,
  output logic              issue_1,
  output logic              issue_2
);

  localparam int NUM_REGS = 2 ** REG_AW;

  typedef enum logic [0:0] {
    ST_PAIR   = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r [NUM_REGS];

  logic issue_1_s;
  logic issue_2_s;
  logic bundle_ready_s;
  logic slot2_clear_s;
  logic load_1_s;
  logic load_2_s;

  // rd_en_1 is consumed only by the dependence checker.
  logic unused_s;
  assign unused_s = rd_en_1;

  // Scoreboard reads: straight from the counters, no bypass of this cycle's loads.
  assign avail_cnt_1 = cnt_r[rd_addr_1];
  assign avail_cnt_2 = cnt_r[rd_addr_2];
  assign avail_cnt_3 = cnt_r[rd_addr_3];
  assign avail_cnt_4 = cnt_r[rd_addr_4];
  assign avail_cnt_5 = cnt_r[rd_addr_5];
  assign avail_cnt_6 = cnt_r[rd_addr_6];

  // Slot 2 may go once it reads nothing, or all of its sources are ready.
  assign slot2_clear_s = !rd_en_2 ||
                         ((avail_cnt_4 == {CNT_W{1'b0}}) &&
                          (avail_cnt_5 == {CNT_W{1'b0}}) &&
                          (avail_cnt_6 == {CNT_W{1'b0}}));

  // Zero latency means "untracked", so it never loads a counter.
  assign load_1_s = issue_1_s && wr_en_1 && (lat_1 != {CNT_W{1'b0}});
  assign load_2_s = issue_2_s && wr_en_2 && (lat_2 != {CNT_W{1'b0}});

  assign issue_1          = issue_1_s;
  assign issue_2          = issue_2_s;
  assign bundle_ready     = bundle_ready_s;
  assign single_stall_reg = (state_r == ST_SECOND);

  // Issue state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_PAIR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Issue decisions and next state. Reset and flush suppress all issue.
  // In SECOND the stall inputs are ignored: a same-destination pair keeps
  // single_stall high forever, so only slot-2 source readiness matters.
  always_comb begin
    issue_1_s      = 1'b0;
    issue_2_s      = 1'b0;
    bundle_ready_s = 1'b0;
    state_next_s   = state_r;
    if (rst || flush) begin
      state_next_s = ST_PAIR;
    end else begin
      case (state_r)
        ST_PAIR: begin
          if (bundle_valid && !both_stall) begin
            issue_1_s = 1'b1;
            if (single_stall) begin
              state_next_s = ST_SECOND;
            end else begin
              issue_2_s      = 1'b1;
              bundle_ready_s = 1'b1;
            end
          end else begin
            state_next_s = ST_PAIR;
          end
        end
        ST_SECOND: begin
          if (slot2_clear_s) begin
            issue_2_s      = 1'b1;
            bundle_ready_s = 1'b1;
            state_next_s   = ST_PAIR;
          end else begin
            state_next_s = ST_SECOND;
          end
        end
        default: begin
          state_next_s = ST_PAIR;
        end
      endcase
    end
  end

  // Countdown counters: load on issue (slot 2 wins a same-register tie),
  // otherwise saturating decrement toward zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load_2_s && (wr_addr_2 == REG_AW'(i))) begin
          cnt_r[i] <= lat_2;
        end else if (load_1_s && (wr_addr_1 == REG_AW'(i))) begin
          cnt_r[i] <= lat_1;
        end else if (cnt_r[i] != {CNT_W{1'b0}}) begin
          cnt_r[i] <= cnt_r[i] - CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_issue_scoreboard_ctrl
//   Randomized bench for issue_scoreboard_ctrl. The reference model records,
//   for each register, the absolute cycle at which its result becomes ready.
//   A count is then (ready_cycle - now) clipped at zero. Bundle progress is a
//   single "slot 1 already out" flag.
// -----------------------------------------------------------------------------
module tb_issue_scoreboard_ctrl;
  localparam int REG_AW = 7;
  localparam int CNT_W  = 4;
  localparam int NR     = 2 ** REG_AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, bundle_valid, flush;
  logic [REG_AW-1:0] rd_addr_1, rd_addr_2, rd_addr_3, rd_addr_4, rd_addr_5, rd_addr_6;
  logic              rd_en_1, rd_en_2, wr_en_1, wr_en_2, both_stall, single_stall;
  logic [REG_AW-1:0] wr_addr_1, wr_addr_2;
  logic [CNT_W-1:0]  lat_1, lat_2;
  logic              bundle_ready, single_stall_reg, issue_1, issue_2;
  logic [CNT_W-1:0]  avail_cnt_1, avail_cnt_2, avail_cnt_3, avail_cnt_4, avail_cnt_5, avail_cnt_6;

  issue_scoreboard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bundle_valid(bundle_valid), .bundle_ready(bundle_ready),
    .flush(flush),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .rd_addr_3(rd_addr_3),
    .rd_addr_4(rd_addr_4), .rd_addr_5(rd_addr_5), .rd_addr_6(rd_addr_6),
    .rd_en_1(rd_en_1), .rd_en_2(rd_en_2),
    .wr_addr_1(wr_addr_1), .wr_addr_2(wr_addr_2), .wr_en_1(wr_en_1), .wr_en_2(wr_en_2),
    .lat_1(lat_1), .lat_2(lat_2), .both_stall(both_stall), .single_stall(single_stall),
    .avail_cnt_1(avail_cnt_1), .avail_cnt_2(avail_cnt_2), .avail_cnt_3(avail_cnt_3),
    .avail_cnt_4(avail_cnt_4), .avail_cnt_5(avail_cnt_5), .avail_cnt_6(avail_cnt_6),
    .single_stall_reg(single_stall_reg), .issue_1(issue_1), .issue_2(issue_2)
  );

  int checks   = 0;
  int failures = 0;
  int now      = 0;
  int ready_at [NR];
  bit slot1_out  = 1'b0;
  bit new_bundle = 1'b1;
  bit reset_done = 1'b0;

  // Compare one observed value against the bench's expectation.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, now);
    end
  endtask

  function automatic int avail_m(input int a);
    return (ready_at[a] > now) ? (ready_at[a] - now) : 0;
  endfunction

  // Evaluate one cycle: check the outputs against the model, advance the model, clock.
  task automatic step();
    int         ra [6];
    int         ea [6];
    logic [3:0] av [6];
    bit         e1, e2, ebr, cur;
    #1;
    ra = '{int'(rd_addr_1), int'(rd_addr_2), int'(rd_addr_3),
           int'(rd_addr_4), int'(rd_addr_5), int'(rd_addr_6)};
    av = '{avail_cnt_1, avail_cnt_2, avail_cnt_3, avail_cnt_4, avail_cnt_5, avail_cnt_6};
    if (rst) begin
      foreach (ready_at[i]) ready_at[i] = 0;
      slot1_out = 1'b0;
    end
    for (int i = 0; i < 6; i++) ea[i] = avail_m(ra[i]);
    cur = slot1_out;
    e1 = 1'b0; e2 = 1'b0; ebr = 1'b0;
    if (rst || flush) begin
      slot1_out = 1'b0;
    end else if (!slot1_out) begin
      if (bundle_valid && !both_stall) begin
        e1 = 1'b1;
        if (single_stall) slot1_out = 1'b1;
        else begin e2 = 1'b1; ebr = 1'b1; end
      end
    end else if (!rd_en_2 || (ea[3] == 0 && ea[4] == 0 && ea[5] == 0)) begin
      e2 = 1'b1; ebr = 1'b1; slot1_out = 1'b0;
    end
    chk("issue_1", issue_1, e1);
    chk("issue_2", issue_2, e2);
    chk("bundle_ready", bundle_ready, ebr);
    chk("single_stall_reg", single_stall_reg, cur);
    for (int i = 0; i < 6; i++) chk($sformatf("avail_cnt_%0d", i + 1), av[i], ea[i]);
    if (e1 && wr_en_1 && lat_1 != 4'd0) ready_at[wr_addr_1] = now + 1 + int'(lat_1);
    if (e2 && wr_en_2 && lat_2 != 4'd0) ready_at[wr_addr_2] = now + 1 + int'(lat_2);
    new_bundle = rst || flush || ebr || (!cur && !bundle_valid);
    @(posedge clk);
    now++;
    @(negedge clk);
  endtask

  function automatic logic [REG_AW-1:0] pick();
    return ($urandom_range(0, 3) == 0) ? REG_AW'($urandom_range(0, NR - 1))
                                       : REG_AW'($urandom_range(0, 7));
  endfunction

  task automatic rand_bundle();
    bundle_valid = ($urandom_range(0, 9) != 0);
    rd_addr_1 = pick(); rd_addr_2 = pick(); rd_addr_3 = pick();
    rd_addr_4 = pick(); rd_addr_5 = pick(); rd_addr_6 = pick();
    rd_en_1   = ($urandom_range(0, 3) != 0);
    rd_en_2   = ($urandom_range(0, 3) != 0);
    wr_addr_1 = pick(); wr_addr_2 = pick();
    wr_en_1   = ($urandom_range(0, 3) != 0);
    wr_en_2   = ($urandom_range(0, 3) != 0);
    lat_1     = CNT_W'($urandom_range(0, 15));
    lat_2     = CNT_W'($urandom_range(0, 15));
  endtask

  task automatic set_rd(input logic [REG_AW-1:0] a);
    rd_addr_1 = a; rd_addr_2 = a; rd_addr_3 = a;
    rd_addr_4 = a; rd_addr_5 = a; rd_addr_6 = a;
  endtask

  // Walk every register through the read ports while idle.
  task automatic sweep();
    bundle_valid = 1'b0; flush = 1'b0; both_stall = 1'b0; single_stall = 1'b0;
    for (int b = 0; b < NR; b += 6) begin
      rd_addr_1 = REG_AW'(b);     rd_addr_2 = REG_AW'(b + 1); rd_addr_3 = REG_AW'(b + 2);
      rd_addr_4 = REG_AW'(b + 3); rd_addr_5 = REG_AW'(b + 4); rd_addr_6 = REG_AW'(b + 5);
      step();
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; both_stall = 1'b0; single_stall = 1'b0;
    rand_bundle();
    bundle_valid = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    sweep();

    // Clean bundle writing r5 with latency 3, then watch it count down.
    bundle_valid = 1'b1; set_rd(REG_AW'(5)); rd_en_2 = 1'b1;
    wr_addr_1 = REG_AW'(5); wr_en_1 = 1'b1; lat_1 = 4'd3; wr_en_2 = 1'b0;
    step();
    bundle_valid = 1'b0;
    repeat (5) step();

    // Both slots write r12 (4 then 2), single_stall held, slot 2 reads r12.
    bundle_valid = 1'b1; set_rd(REG_AW'(12)); rd_en_2 = 1'b1; single_stall = 1'b1;
    wr_addr_1 = REG_AW'(12); wr_addr_2 = REG_AW'(12);
    wr_en_1 = 1'b1; wr_en_2 = 1'b1; lat_1 = 4'd4; lat_2 = 4'd2;
    repeat (8) begin
      step();
      if (new_bundle) bundle_valid = 1'b0;
    end
    single_stall = 1'b0;
    repeat (3) step();

    // Split a bundle waiting on r9, then flush while slot 2 is pending.
    bundle_valid = 1'b1; set_rd(REG_AW'(9)); wr_addr_1 = REG_AW'(9);
    wr_en_1 = 1'b1; lat_1 = 4'd6; wr_en_2 = 1'b0;
    step();
    single_stall = 1'b1;
    step();
    single_stall = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; bundle_valid = 1'b0;
    repeat (2) step();

    // Randomized traffic with occasional flushes and one reset mid-SECOND.
    for (int i = 0; i < 3000; i++) begin
      if (new_bundle) rand_bundle();
      both_stall   = ($urandom_range(0, 4) == 0);
      single_stall = ($urandom_range(0, 2) == 0);
      flush        = ($urandom_range(0, 49) == 0);
      if (i >= 1500 && !reset_done && slot1_out) begin
        rst = 1'b1; flush = 1'b0;
        step();
        rst = 1'b0; reset_done = 1'b1;
        sweep();
        new_bundle = 1'b1;
      end else begin
        step();
      end
    end
    chk("reset_mid_second_seen", reset_done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
